seq_karatsuba_mul: RTL and testbench
====================================

SEQ_KARATSUBA_MUL -- requirements
Module: seq_karatsuba_mul

Interface
REQ-001 Parameter: N, default 16, operand width; even, >= 4.
REQ-002 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port: rst, input, 1, reset; synchronous, active-high.
REQ-004 Port: in_valid, input, 1, operands and mode present.
REQ-005 Port: in_ready, output, 1, block can accept a new operation.
REQ-006 Port: in_x, input, N, multiplicand.
REQ-007 Port: in_y, input, N, multiplier.
REQ-008 Port: in_signed, input, 1, 1 = two's-complement operands, 0 = unsigned.
REQ-009 Port: out_valid, output, 1, out_product holds a finished result.
REQ-010 Port: out_ready, input, 1, consumer takes the result.
REQ-011 Port: out_product, output, 2N, product; two's complement when the captured mode is signed.

Function
REQ-012 Accept on a rising edge with in_valid & in_ready; capture in_x, in_y and in_signed on that edge.
REQ-013 in_ready SHALL be 1 only in state IDLE; inputs at all other times SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, MUL_HI, MUL_LO, MUL_MID, COMBINE and DONE.
REQ-015 FSM transitions SHALL be: IDLE->MUL_HI on accept, then one state per edge unconditionally through MUL_LO, MUL_MID and COMBINE to DONE.
REQ-016 DONE->IDLE on the edge with out_ready=1; otherwise stay in DONE.
REQ-017 Signed mode: operands SHALL be converted to N-bit magnitudes at capture, and the sign flag SHALL be registered as sign(x) XOR sign(y).
REQ-018 The magnitude of -2^(N-1) SHALL be represented as 2^(N-1) without overflow.
REQ-019 With H = N/2, split each magnitude into hi/lo H-bit halves.
REQ-020 MUL_HI SHALL register p_hh = xh*yh.
REQ-021 MUL_LO SHALL register p_ll = xl*yl.
REQ-022 MUL_MID SHALL register p_m = (xh+xl)*(yh+yl), using (H+1)-bit sums and a (2H+2)-bit product.
REQ-023 All three products SHALL go through one shared multiplier instance, time-multiplexed.
REQ-024 COMBINE SHALL register result = p_hh<<N + (p_m - p_hh - p_ll)<<H + p_ll, computed at 2N+1 bits and truncated to 2N bits (exact).
REQ-025 In COMBINE, if the sign flag is set, the 2N-bit result SHALL be negated.
REQ-026 Latency: out_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-027 Minimum initiation interval SHALL be 6 cycles.
REQ-028 out_valid SHALL be 1 only in DONE.
REQ-029 out_product SHALL stay stable while out_valid & !out_ready (backpressure, no limit on duration).
REQ-030 out_product SHALL hold its last value after DONE->IDLE until the next COMBINE.
REQ-031 Unsigned mode SHALL give the exact unsigned 2N-bit product for all inputs, including 0 and all-ones.
REQ-032 in_signed=1 with both operands zero SHALL give 0 (no -0 artefact).

Reset
REQ-033 While rst=1 at a rising edge, the FSM SHALL go to IDLE, regardless of state, including mid-operation and in DONE under backpressure.
REQ-034 Reset SHALL clear out_valid to 0 and out_product to 0 and discard the in-flight operation.
REQ-035 Reset SHALL clear p_hh, p_ll, p_m and the sign flag to 0.
REQ-036 in_ready SHALL be 0 during the reset cycle and 1 on the first cycle after rst falls.
REQ-037 An in_valid asserted while rst=1 SHALL NOT be accepted.

Structure
REQ-038 Shared package kara_pkg SHALL hold the FSM state enum typedef and width helper constants (H, H+1, 2H+2, 2N+1), derived from N.
REQ-039 One sub-module, kara_half_mul, SHALL be a combinational (H+1)x(H+1) unsigned multiplier built from the team's existing full_adder/rca_Nbit primitives, instantiated once.
REQ-040 No other arithmetic sub-modules; the add, subtract and negate steps SHALL live in seq_karatsuba_mul.

Verification
REQ-041 With N=16, unsigned, 0x1234 x 0x5678 SHALL give out_product=0x06260060, with out_valid 4 edges after accept.
REQ-042 With N=16, unsigned, 0xFFFF x 0xFFFF SHALL give 0xFFFE0001; 0x0000 x 0xFFFF SHALL give 0x00000000.
REQ-043 With N=16, signed, 0x8000 x 0x8000 SHALL give 0x40000000.
REQ-044 With N=16, signed, 0xFFFF x 0x8000 SHALL give 0x00008000; 0x0003 x 0xFFFE SHALL give 0xFFFFFFFA.
REQ-045 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_product unchanged, in_ready=0 throughout, and a new in_valid is not accepted; after out_ready=1, accept on the next edge.
REQ-046 rst pulse in MUL_MID -> next cycle IDLE, out_valid=0, out_product=0; a following 7 x 9 unsigned operation SHALL give 63.
REQ-047 Random soak: 10000 random operands in both modes with random out_ready, checked against a reference model of the product.

Source files
------------

// File: rtl/kara_pkg.sv
// Shared FSM encoding and width helpers for the sequential Karatsuba multiplier.
package kara_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_HI  = 3'd1,
        MUL_LO  = 3'd2,
        MUL_MID = 3'd3,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } kara_state_e;

    // Widths derived from the operand width n: H, H+1, 2H+2 and 2N+1.
    function automatic int half_w(input int n);
        return n / 2;
    endfunction

    function automatic int sum_w(input int n);
        return n / 2 + 1;
    endfunction

    function automatic int mid_w(input int n);
        return 2 * (n / 2) + 2;
    endfunction

    function automatic int wide_w(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the building block of the ripple-carry adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/kara_half_mul.sv
// Combinational (H+1)x(H+1) unsigned array multiplier shared by all Karatsuba partial products.
module kara_half_mul
    import kara_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [sum_w(N)-1:0]   a,
    input  logic [sum_w(N)-1:0]   b,
    output logic [2*sum_w(N)-1:0] p
);

    localparam int W = sum_w(N);

    logic [W-1:0] pp [W];
    logic [W-1:0] hi [W];

    for (genvar i = 0; i < W; i++) begin : g_pp
        assign pp[i] = a & {W{b[i]}};
    end

    // Each row retires one product bit; hi carries the upper W bits of the running sum.
    assign p[0]  = pp[0][0];
    assign hi[0] = {1'b0, pp[0][W-1:1]};

    for (genvar i = 1; i < W; i++) begin : g_row
        logic [W-1:0] s;
        logic         c;

        rca_Nbit #(.WIDTH(W)) u_rca (
            .a   (hi[i-1]),
            .b   (pp[i]),
            .cin (1'b0),
            .sum (s),
            .cout(c)
        );

        assign p[i]  = s[0];
        assign hi[i] = {c, s[W-1:1]};
    end

    assign p[2*W-1:W] = hi[W-1];

endmodule

// File: rtl/rca_Nbit.sv
// Parameterised ripple-carry adder built from a chain of full adders.
module rca_Nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_karatsuba_mul.sv
// Sequential signed/unsigned Karatsuba multiplier: three products through one shared
// multiplier, then a combine step, with a valid/ready handshake on both sides.
module seq_karatsuba_mul
    import kara_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_x,
    input  logic [N-1:0]   in_y,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_product
);

    localparam int H  = half_w(N);
    localparam int HS = sum_w(N);
    localparam int PM = mid_w(N);
    localparam int WW = wide_w(N);
    localparam int PW = 2 * N;

    kara_state_e   state;
    logic [N-1:0]  x_mag;
    logic [N-1:0]  y_mag;
    logic          neg;
    logic [PM-1:0] p_hh;
    logic [PM-1:0] p_ll;
    logic [PM-1:0] p_m;
    logic [PM-1:0] mul_p;
    logic [HS-1:0] mul_a;
    logic [HS-1:0] mul_b;
    logic [PW-1:0] product;
    logic [PW-1:0] sum_raw;
    logic [PW-1:0] combined;
    logic [N-1:0]  x_abs;
    logic [N-1:0]  y_abs;
    logic          x_neg;
    logic          y_neg;
    logic          accept;

    assign in_ready    = (state == IDLE) && !rst;
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state == DONE);
    assign out_product = product;

    // N-bit magnitudes: -2^(N-1) negates onto itself, which is already the right unsigned value.
    assign x_neg = in_signed && in_x[N-1];
    assign y_neg = in_signed && in_y[N-1];
    assign x_abs = x_neg ? (~in_x + 1'b1) : in_x;
    assign y_abs = y_neg ? (~in_y + 1'b1) : in_y;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MUL_HI: begin
                mul_a = {1'b0, x_mag[N-1:H]};
                mul_b = {1'b0, y_mag[N-1:H]};
            end
            MUL_LO: begin
                mul_a = {1'b0, x_mag[H-1:0]};
                mul_b = {1'b0, y_mag[H-1:0]};
            end
            MUL_MID: begin
                mul_a = {1'b0, x_mag[N-1:H]} + {1'b0, x_mag[H-1:0]};
                mul_b = {1'b0, y_mag[N-1:H]} + {1'b0, y_mag[H-1:0]};
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    kara_half_mul #(.N(N)) u_half_mul (
        .a(mul_a),
        .b(mul_b),
        .p(mul_p)
    );

    // The middle term is xh*yl + xl*yh, always non-negative, so 2N+1 bits never wrap.
    assign sum_raw  = PW'((WW'(p_hh) << N)
                        + ((WW'(p_m) - WW'(p_hh) - WW'(p_ll)) << H)
                        + WW'(p_ll));
    assign combined = neg ? (~sum_raw + 1'b1) : sum_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x_mag   <= '0;
            y_mag   <= '0;
            neg     <= 1'b0;
            p_hh    <= '0;
            p_ll    <= '0;
            p_m     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_mag <= x_abs;
                        y_mag <= y_abs;
                        neg   <= x_neg ^ y_neg;
                        state <= MUL_HI;
                    end
                end
                MUL_HI: begin
                    p_hh  <= mul_p;
                    state <= MUL_LO;
                end
                MUL_LO: begin
                    p_ll  <= mul_p;
                    state <= MUL_MID;
                end
                MUL_MID: begin
                    p_m   <= mul_p;
                    state <= COMBINE;
                end
                COMBINE: begin
                    product <= combined;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_karatsuba_mul.sv
// Self-checking bench for seq_karatsuba_mul: directed corners, backpressure, reset
// mid-operation and a random soak against a plain-arithmetic product model.
module tb_seq_karatsuba_mul;

    localparam int N  = 16;
    localparam int PW = 2 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_x;
    logic [N-1:0]  in_y;
    logic          in_signed;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_karatsuba_mul #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_signed  (in_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product)
    );

    // Reference: widen to 64-bit integers, multiply, keep the low 2N bits.
    function automatic logic [PW-1:0] refProduct(input logic [N-1:0] x, input logic [N-1:0] y,
                                                 input logic s);
        longint a;
        longint b;
        if (s) begin
            a = longint'($signed(x));
            b = longint'($signed(y));
        end else begin
            a = longint'(x);
            b = longint'(y);
        end
        return PW'(a * b);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One full transaction: accept, latency, result, optional backpressure, release.
    task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                                 input logic [PW-1:0] expected, input int hold, input string tag);
        int waited;
        int lat;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, " ready wait"}, 64'(waited), 64'd0);
        in_x      = x;
        in_y      = y;
        in_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 12) begin
            in_valid  = 1'($urandom);
            in_x      = N'($urandom);
            in_y      = N'($urandom);
            in_signed = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'd4);
        checkOutput({tag, " product"}, 64'(out_product), 64'(expected));
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_x      = N'($urandom);
            in_y      = N'($urandom);
            @(negedge clk);
            checkOutput({tag, " held valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, " held in_ready"}, 64'(in_ready), 64'd0);
            checkOutput({tag, " held product"}, 64'(out_product), 64'(expected));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " released valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " kept product"}, 64'(out_product), 64'(expected));
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] corners [5];
        logic [N-1:0] rx;
        logic [N-1:0] ry;
        logic         rs;

        corners[0] = 16'h0000;
        corners[1] = 16'hFFFF;
        corners[2] = 16'h8000;
        corners[3] = 16'h7FFF;
        corners[4] = 16'h0001;

        // Reset with in_valid held high: nothing may be accepted.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_x      = 16'h0003;
        in_y      = 16'h0005;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset product", 64'(out_product), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("post-reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        checkOutput("idle after reset", 64'(in_ready), 64'd1);

        applyStimulus(16'h1234, 16'h5678, 1'b0, 32'h06260060, 0, "u 1234x5678");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, "u FFFFxFFFF");
        applyStimulus(16'h0000, 16'hFFFF, 1'b0, 32'h00000000, 0, "u 0000xFFFF");
        applyStimulus(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, "s 8000x8000");
        applyStimulus(16'hFFFF, 16'h8000, 1'b1, 32'h00008000, 0, "s FFFFx8000");
        applyStimulus(16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA, 0, "s 0003xFFFE");
        applyStimulus(16'h0000, 16'h0000, 1'b1, 32'h00000000, 0, "s zero");
        applyStimulus(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 10, "backpressure");
        applyStimulus(16'h7FFF, 16'h8001, 1'b1, 32'hC000FFFF, 0, "after backpressure");

        // Reset while the middle product is being formed.
        in_x      = 16'hABCD;
        in_y      = 16'h1357;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid reset product", 64'(out_product), 64'd0);
        checkOutput("mid reset in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid reset idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        applyStimulus(16'd7, 16'd9, 1'b0, 32'd63, 0, "7x9 after reset");

        for (int i = 0; i < 10000; i++) begin
            rx = N'($urandom);
            ry = N'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) rx = corners[$urandom_range(0, 4)];
            if (i % 8 == 4) ry = corners[$urandom_range(0, 4)];
            applyStimulus(rx, ry, rs, refProduct(rx, ry, rs),
                          ($urandom_range(0, 3) == 0) ? 1 : 0, $sformatf("soak %0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
